// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and phase helpers for the VGA timing controller.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    localparam int DEF_DIV      = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int phase_len(phase_t p, int act, int fp, int sync, int bp);
        int len;
        case (p)
            PH_ACT:  len = act;
            PH_FP:   len = fp;
            PH_SYNC: len = sync;
            default: len = bp;
        endcase
        return len;
    endfunction

    // Last count value that belongs to phase p.
    function automatic int phase_end(phase_t p, int act, int fp, int sync, int bp);
        int e;
        case (p)
            PH_ACT:  e = act - 1;
            PH_FP:   e = act + fp - 1;
            PH_SYNC: e = act + fp + sync - 1;
            default: e = act + fp + sync + bp - 1;
        endcase
        return e;
    endfunction

    // Following phase in the cycle, skipping any phase of zero length.
    function automatic phase_t next_phase(phase_t p, int act, int fp, int sync, int bp);
        phase_t n;
        logic   found;
        n     = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found) begin
                n     = phase_t'(n + 2'd1);
                found = phase_len(n, act, fp, sync, bp) > 0;
            end
        end
        return n;
    endfunction

    // Phase that owns the final count of the axis (the reset position).
    function automatic phase_t last_phase(int fp, int sync, int bp);
        phase_t p;
        if (bp > 0)        p = PH_BP;
        else if (sync > 0) p = PH_SYNC;
        else if (fp > 0)   p = PH_FP;
        else               p = PH_ACT;
        return p;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Control and pixel-timing bundle of vga_timing_ctrl; frame_cnt exists only with VGA_FRAME_CNT_EN.
interface vga_timing_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          ena;
    logic          restart;
    logic          pix_stb;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    modport master (
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        input  ena, restart,
        output pix_stb, hsync, vsync, active, x, y, line_start, frame_start
    );

    modport slave (
`ifdef VGA_FRAME_CNT_EN
        input  frame_cnt,
`endif
        output ena, restart,
        input  pix_stb, hsync, vsync, active, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_timer.sv
// One timing axis: position counter plus active/porch/sync phase FSM.
// cnt/phase show the state that takes effect at the coming edge so the caller can register outputs in step.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int TOTAL  = ACTIVE + FP + SYNC + BP,
    parameter int W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         restart,
    output logic [W-1:0] cnt,
    output phase_t       phase,
    output logic         wrap
);
    localparam logic [W-1:0] LAST      = W'(TOTAL - 1);
    localparam phase_t       RST_PHASE = last_phase(FP, SYNC, BP);

    logic [W-1:0] cnt_q, cnt_d;
    phase_t       phase_q, phase_d;
    logic         at_end;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        cnt_d   = cnt_q;
        phase_d = phase_q;
        wrap    = step && (cnt_q == LAST);
        at_end  = cnt_q == W'(phase_end(phase_q, ACTIVE, FP, SYNC, BP));
        if (restart) begin
            cnt_d   = LAST;
            phase_d = RST_PHASE;
        end else if (step) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
            if (at_end) phase_d = next_phase(phase_q, ACTIVE, FP, SYNC, BP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= LAST;
            phase_q <= RST_PHASE;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update together.
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign cnt   = cnt_d;
    assign phase = phase_d;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA frame timing: pixel divider, H/V axis timers and registered sync/blank/coordinate outputs.
// Optional 16-bit frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_ctrl_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef struct packed {
        logic          pix_stb;
        logic          hsync;
        logic          vsync;
        logic          active;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          line_start;
        logic          frame_start;
    } out_t;

    localparam out_t OUT_RST = '{
        pix_stb: 1'b0, hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, active: 1'b0,
        x: '0, y: '0, line_start: 1'b0, frame_start: 1'b0
    };

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    phase_t        h_phase, v_phase;
    logic          h_wrap, v_wrap;
    out_t          out_q, out_d;

    assign tick = bus.ena && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (bus.restart)  div_d = '0;
        else if (bus.ena) div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    vga_axis_timer #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(XW)
    ) u_h_timer (
        .clk(clk), .rst(rst), .step(tick), .restart(bus.restart),
        .cnt(h_cnt), .phase(h_phase), .wrap(h_wrap)
    );

    vga_axis_timer #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(YW)
    ) u_v_timer (
        .clk(clk), .rst(rst), .step(tick && h_wrap), .restart(bus.restart),
        .cnt(v_cnt), .phase(v_phase), .wrap(v_wrap)
    );

    // Without a tick the axis state does not move, so outputs recompute to the values they already hold.
    always_comb begin
        out_d = OUT_RST;
        if (!bus.restart) begin
            out_d.pix_stb     = tick;
            out_d.active      = (h_phase == PH_ACT) && (v_phase == PH_ACT);
            out_d.x           = out_d.active ? h_cnt : '0;
            out_d.y           = out_d.active ? v_cnt : '0;
            out_d.hsync       = (h_phase == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
            out_d.vsync       = (v_phase == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
            out_d.line_start  = h_wrap;
            out_d.frame_start = v_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            out_q <= OUT_RST;
        end else begin
            div_q <= div_d;
            out_q <= out_d;
        end
    end

    assign bus.pix_stb     = out_q.pix_stb;
    assign bus.hsync       = out_q.hsync;
    assign bus.vsync       = out_q.vsync;
    assign bus.active      = out_q.active;
    assign bus.x           = out_q.x;
    assign bus.y           = out_q.y;
    assign bus.line_start  = out_q.line_start;
    assign bus.frame_start = out_q.frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (bus.restart)  frame_cnt_d = '0;
        else if (v_wrap)  frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
